// File: rtl/sumsquare_pkg.sv
// Shared definitions for the sum-of-squares reduction stages:
// fp32 field constants, FSM encoding and lane-count default.
package sumsquare_pkg;

   localparam int unsigned LANES_DEF = 16;
   localparam int unsigned FP_BIAS   = 127;
   localparam logic [31:0] FP_INF    = 32'h7F80_0000;
   localparam logic [31:0] FP_ZERO   = 32'h0000_0000;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FDONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]  exp;
      logic [23:0] sig;
   } fp_unp_t;

   // Magnitude only; exponent 0 flushes to a zero significand.
   function automatic fp_unp_t fp_unpack(input logic [30:0] x);
      fp_unp_t u;
      u.exp = x[30:23];
      u.sig = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
      return u;
   endfunction

endpackage

// File: rtl/sumsquare_accum_fp32_add.sv
// Combinational fp32 adder for non-negative operands:
// flush-to-zero, truncating, saturating to +Inf.
module fp32_add
   import sumsquare_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);

   fp_unp_t     ua;
   fp_unp_t     ub;
   fp_unp_t     big;
   fp_unp_t     sml;
   logic [7:0]  diff;
   logic [23:0] sml_sh;
   logic [24:0] raw;
   logic [8:0]  exp9;
   logic [22:0] frac;
   logic        unused_sign;

   assign unused_sign = a_i[31] | b_i[31];

   always_comb begin
      ua  = fp_unpack(a_i[30:0]);
      ub  = fp_unpack(b_i[30:0]);
      big = (ua.exp >= ub.exp) ? ua : ub;
      sml = (ua.exp >= ub.exp) ? ub : ua;

      diff   = big.exp - sml.exp;
      sml_sh = (diff >= 8'd24) ? 24'd0 : (sml.sig >> diff);
      raw    = {1'b0, big.sig} + {1'b0, sml_sh};

      // The larger operand carries the hidden 1, so only a carry can move it.
      exp9 = {1'b0, big.exp} + {8'd0, raw[24]};
      frac = raw[24] ? raw[23:1] : raw[22:0];

      sum_o = {1'b0, exp9[7:0], frac};
      if (ua.exp == FP_EXP_MAX || ub.exp == FP_EXP_MAX
          || exp9 >= 9'd255) begin
         sum_o = FP_INF;
      end else if (big.exp == 8'd0) begin
         sum_o = FP_ZERO;
      end
   end

endmodule

// File: rtl/sumsquare_accum.sv
// Serial fp32 reduction of one captured batch of lane squares,
// optionally seeded with the previous total.
module sumsquare_accum
   import sumsquare_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             ACCUM,
   input  logic [LANES*W-1:0] pipein,
   output logic             READY,
   output logic             BUSY,
   output logic             DONE,
   output logic [W-1:0]     SUM
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   state_e        state_q;
   state_e        state_d;
   logic [W-1:0]  lanes_q [LANES];
   logic [IW-1:0] idx_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  sum_q;
   logic [W-1:0]  add_res;
   logic          start;

   assign start = EN && READY;
   assign SUM   = sum_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (idx_q == LAST) state_d = ST_FDONE;
         end
         ST_FDONE: begin
            state_d = start ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      READY = 1'b1;
      BUSY  = 1'b0;
      DONE  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            READY = 1'b0;
            BUSY  = 1'b1;
         end
         ST_FDONE: DONE = 1'b1;
         default: ;
      endcase
   end

   // lane0 sits in the MSBs of pipein.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < LANES; i++) begin
            lanes_q[i] <= pipein[(LANES-1-i)*W +: W];
         end
      end
   end

   fp32_add u_add (
      .a_i   (acc_q),
      .b_i   (lanes_q[idx_q]),
      .sum_o (add_res)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_q <= FP_ZERO;
         idx_q <= '0;
         sum_q <= FP_ZERO;
      end else if (start) begin
         acc_q <= ACCUM ? sum_q : FP_ZERO;
         idx_q <= '0;
      end else if (state_q == ST_RUN) begin
         acc_q <= add_res;
         idx_q <= idx_q + 1'b1;
         if (idx_q == LAST) sum_q <= add_res;
      end
   end

endmodule
